// File: rtl/instruction_fifo_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fifo_frontend
//  Description : Host-facing instruction FIFO ahead of the GPU control unit.
//                Queues {data_a, data_b} words written by the host, presents
//                the head entry with en_execution and retires it on done_inst.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fifo_frontend #(
  parameter int DEPTH  = 16,   // FIFO entries, must equal 2**ADDR_W
  parameter int ADDR_W = 4,    // pointer width
  parameter int DATA_W = 32    // width of each instruction word
) (
  input  logic              clk,
  input  logic              reset,         // synchronous, active-low
  input  logic              wr_reg,
  input  logic [DATA_W-1:0] data_a_in,
  input  logic [DATA_W-1:0] data_b_in,
  input  logic              done_inst,
  output logic              en_execution,
  output logic [3:0]        op_code,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  // Sequencer states; en_execution is decoded straight from the state register
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ISSUE  = 2'd2,
    S_RETIRE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   C_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic                wr_reg_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   head_a_q, head_b_q;
  logic [2*DATA_W-1:0] mem_q [DEPTH];

  logic wr_pulse;
  logic wr_accept;
  logic wr_drop;
  logic pop;
  logic full;

  // Full/empty come from the occupancy count, never from pointer compare,
  // so the pointers are free to wrap naturally.
  assign full      = (count_q == C_DEPTH);
  assign wr_pulse  = wr_reg & ~wr_reg_q;
  assign wr_accept = wr_pulse & ~full;
  // A retire in the same cycle does not rescue a write into a full FIFO:
  // the slot is only freed after this edge.
  assign wr_drop   = wr_pulse & full;
  assign pop       = (state_q == S_RETIRE);

  // Pointer, count and overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
    if (wr_accept && !pop) begin
      count_d = count_q + C_CNT_ONE;
    end else if (!wr_accept && pop) begin
      count_d = count_q - C_CNT_ONE;
    end
    if (wr_drop) begin
      overflow_d = 1'b1;
    end
  end

  // Write-strobe edge detector and FIFO bookkeeping registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_reg_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_reg_q   <= wr_reg;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array write port; contents are not reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= {data_a_in, data_b_in};
    end
  end

  // Synchronous read port: head registers capture the entry only in LOAD
  // and then hold it until the next LOAD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_a_q <= '0;
      head_b_q <= '0;
    end else if (state_q == S_LOAD) begin
      {head_a_q, head_b_q} <= mem_q[rd_ptr_q];
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next-state; done_inst only matters while in ISSUE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_LOAD;
      S_LOAD:   state_d = S_ISSUE;
      S_ISSUE:  if (done_inst) state_d = S_RETIRE;
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign en_execution = (state_q == S_ISSUE);
  assign data_a       = head_a_q;
  assign data_b       = head_b_q;
  assign op_code      = head_a_q[3:0];
  assign fifo_full    = full;
  assign fifo_empty   = (count_q == '0);
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire
